// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_pkg
//  Description : Shared types and helpers for the sequential MAC array:
//                controller state encoding and the saturating/wrapping adder
//                used by every accumulator cell.
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    // Controller states; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Widest accumulator supported by sat_add.
    localparam int C_MAX_ACC_W = 64;

    // Adds two values that are already sign-extended from a w-bit range.
    // Saturating mode clamps the exact sum to the signed w-bit range.
    // Wrapping mode keeps the low w bits and sign-extends them.
    // The sum is formed in one extra bit, so it never overflows internally.
    // w is constant at every call site, so all shifts fold to wiring.
    function automatic logic signed [C_MAX_ACC_W-1:0] sat_add(
        input logic signed [C_MAX_ACC_W-1:0] a,
        input logic signed [C_MAX_ACC_W-1:0] b,
        input int                            w,
        input logic                          sat
    );
        logic signed [C_MAX_ACC_W:0] s;
        logic signed [C_MAX_ACC_W:0] hi;
        logic signed [C_MAX_ACC_W:0] lo;
        logic signed [C_MAX_ACC_W:0] r;
        s  = {a[C_MAX_ACC_W-1], a} + {b[C_MAX_ACC_W-1], b};
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -(65'sd1 <<< (w - 1));
        if (sat) begin
            if (s > hi) begin
                r = hi;
            end else if (s < lo) begin
                r = lo;
            end else begin
                r = s;
            end
        end else begin
            r = (s <<< (C_MAX_ACC_W + 1 - w)) >>> (C_MAX_ACC_W + 1 - w);
        end
        return r[C_MAX_ACC_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_cell_sat.sv
`default_nettype none
// ============================================================================
//  Module      : mac_cell_sat
//  Description : One accumulator of the MAC array. It is cleared
//                synchronously and adds the incoming product when enabled,
//                either saturating or wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_cell_sat
    import mac_pkg::*;
#(
    parameter int ACC_WIDTH  = 32,
    parameter int PROD_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clr,
    input  logic                         i_en,
    input  logic                         i_sat_en,
    input  logic signed [PROD_WIDTH-1:0] i_prod,
    output logic signed [ACC_WIDTH-1:0]  o_acc
);

    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic signed [C_MAX_ACC_W-1:0] w_sum;
    logic                          w_unused_sum;

    // Both operands are sign-extended to the common adder width.
    assign w_sum = sat_add(C_MAX_ACC_W'(r_acc), C_MAX_ACC_W'(i_prod),
                           ACC_WIDTH, i_sat_en);

    // The upper bits only repeat the sign of the low ACC_WIDTH bits.
    assign w_unused_sum = ^w_sum;

    // Accumulator register: reset or clear wins over enable.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_sum[ACC_WIDTH-1:0];
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/mac_array_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mac_array_seq
//  Description : Sequential M x M outer-product MAC array. Each accepted beat
//                (column of A, row of B) is added into all accumulators.
//                After k_len beats, the result is streamed out one row at a
//                time under valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_array_seq
    import mac_pkg::*;
#(
    parameter int M         = 4,
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int ACC_WIDTH = 32,
    parameter int K_WIDTH   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [K_WIDTH-1:0]              k_len,
    input  logic                            sat_en,
    output logic                            busy,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [M-1:0][A_WIDTH-1:0]       a_col,
    input  logic [M-1:0][B_WIDTH-1:0]       b_row,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [M-1:0][ACC_WIDTH-1:0]     out_row,
    output logic [$clog2(M)-1:0]            out_idx,
    output logic                            out_last,
    output logic                            done
);

    localparam int C_PROD_W = A_WIDTH + B_WIDTH;
    localparam int C_IDX_W  = $clog2(M);

    state_t               r_state;
    state_t               w_state_next;
    logic [K_WIDTH-1:0]   r_k_len;
    logic                 r_sat_en;
    logic [K_WIDTH-1:0]   r_beat_cnt;
    logic [C_IDX_W-1:0]   r_row_idx;
    logic                 r_done;

    logic                 w_start;
    logic                 w_accept;
    logic                 w_last_beat;
    logic                 w_out_hs;
    logic                 w_last_row;

    logic [ACC_WIDTH-1:0] w_acc [M][M];

    assign w_start     = (r_state == IDLE) && start;
    assign w_accept    = (r_state == ACCUM) && in_valid;
    assign w_last_beat = w_accept && ((r_beat_cnt + K_WIDTH'(1)) == r_k_len);
    assign w_last_row  = (r_row_idx == C_IDX_W'(M - 1));
    assign w_out_hs    = (r_state == DRAIN) && out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a zero-length job goes straight to DRAIN.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = (k_len == '0) ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                if (w_last_beat) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_out_hs && w_last_row) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Job configuration, beat counter, row index and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k_len    <= '0;
            r_sat_en   <= 1'b0;
            r_beat_cnt <= '0;
            r_row_idx  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_out_hs && w_last_row;
            if (w_start) begin
                r_k_len    <= k_len;
                r_sat_en   <= sat_en;
                r_beat_cnt <= '0;
                r_row_idx  <= '0;
            end else begin
                if (w_accept) begin
                    r_beat_cnt <= r_beat_cnt + K_WIDTH'(1);
                end
                if (w_out_hs) begin
                    r_row_idx <= w_last_row ? '0 : r_row_idx + C_IDX_W'(1);
                end
            end
        end
    end

    // M x M accumulator grid; cell (i,j) accumulates a_col[i] * b_row[j].
    for (genvar gi = 0; gi < M; gi++) begin : g_row
        for (genvar gj = 0; gj < M; gj++) begin : g_col
            logic signed [C_PROD_W-1:0] w_prod;
            assign w_prod = C_PROD_W'($signed(a_col[gi])) * C_PROD_W'($signed(b_row[gj]));
            mac_cell_sat #(
                .ACC_WIDTH  (ACC_WIDTH),
                .PROD_WIDTH (C_PROD_W)
            ) u_cell (
                .clk      (clk),
                .rst      (rst),
                .i_clr    (w_start),
                .i_en     (w_accept),
                .i_sat_en (r_sat_en),
                .i_prod   (w_prod),
                .o_acc    (w_acc[gi][gj])
            );
        end
    end

    // Output row mux; the row reads zero outside DRAIN.
    always_comb begin
        out_row = '0;
        if (r_state == DRAIN) begin
            for (int j = 0; j < M; j++) begin
                out_row[j] = w_acc[r_row_idx][j];
            end
        end
    end

    assign busy      = (r_state != IDLE);
    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == DRAIN);
    assign out_idx   = r_row_idx;
    assign out_last  = out_valid && w_last_row;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mac_array_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_array_seq
//  Description : Self-checking bench for mac_array_seq (M=4, 8x8-bit operands,
//                16-bit accumulators), using an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_array_seq;

    localparam int M   = 4;
    localparam int AW  = 8;
    localparam int BW  = 8;
    localparam int ACC = 16;
    localparam int KW  = 16;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     start = 1'b0;
    logic [KW-1:0]            k_len = '0;
    logic                     sat_en = 1'b0;
    logic                     busy;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [M-1:0][AW-1:0]     a_col = '0;
    logic [M-1:0][BW-1:0]     b_row = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [M-1:0][ACC-1:0]    out_row;
    logic [1:0]               out_idx;
    logic                     out_last;
    logic                     done;

    always #5 clk = ~clk;

    mac_array_seq #(
        .M(M), .A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(ACC), .K_WIDTH(KW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .sat_en(sat_en),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
        .a_col(a_col), .b_row(b_row), .out_valid(out_valid),
        .out_ready(out_ready), .out_row(out_row), .out_idx(out_idx),
        .out_last(out_last), .done(done)
    );

    int     n_tests = 0;
    int     n_fail  = 0;
    int     a_b [16][M];
    int     b_b [16][M];
    longint exp_mat [M][M];
    longint got_mat [M][M];
    int     exp_row  = 0;
    int     done_cnt = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One step of the reference: exact sum, then clamp or wrap to 16 bits.
    function automatic longint model_add(input longint acc, input longint p, input bit sat);
        longint s;
        s = acc + p;
        if (sat) begin
            if (s > 32767)  return 32767;
            if (s < -32768) return -32768;
            return s;
        end
        s = s & 64'hFFFF;
        if (s > 32767) s = s - 65536;
        return s;
    endfunction

    // C[i][j] = running sum over beats t of A[i][t] * B[t][j].
    function automatic void build_model(input int k, input bit sat);
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < M; j++) begin
                exp_mat[i][j] = 0;
                got_mat[i][j] = 99999;
                for (int t = 0; t < k; t++) begin
                    exp_mat[i][j] = model_add(exp_mat[i][j], longint'(a_b[t][i] * b_b[t][j]), sat);
                end
            end
        end
    endfunction

    // Compare process: row contents on each handshake, and hold during stalls.
    logic                  prev_stall = 1'b0;
    logic [M-1:0][ACC-1:0] prev_row;
    logic [1:0]            prev_idx;
    logic                  prev_last;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", longint'(out_valid), 1);
                check("hold_row", longint'(out_row), longint'(prev_row));
                check("hold_idx", longint'(out_idx), longint'(prev_idx));
                check("hold_last", longint'(out_last), longint'(prev_last));
            end
            if (out_valid && out_ready) begin
                check("row_idx", longint'(out_idx), exp_row);
                check("row_last", longint'(out_last), (exp_row == M - 1) ? 1 : 0);
                for (int j = 0; j < M; j++) begin
                    check("row_data", longint'($signed(out_row[j])), exp_mat[exp_row][j]);
                    got_mat[out_idx][j] = longint'($signed(out_row[j]));
                end
                exp_row = (exp_row + 1) % M;
            end
            if (out_valid && in_ready) check("valid_ready_excl", 1, 0);
            if (done) done_cnt++;
            prev_stall = out_valid && !out_ready;
            prev_row   = out_row;
            prev_idx   = out_idx;
            prev_last  = out_last;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_beat(input int t);
        for (int i = 0; i < M; i++) begin
            a_col[i] = a_b[t][i][AW-1:0];
            b_row[i] = b_b[t][i][BW-1:0];
        end
    endtask

    task automatic run_job(input int k, input bit sat, input bit rnd_in,
                           input bit rnd_out, input bit start_in_drain);
        int beat  = 0;
        int guard = 0;
        int d0    = done_cnt;
        bit acc;
        build_model(k, sat);
        exp_row = 0;
        start = 1'b1; k_len = KW'(k); sat_en = sat;
        tick;
        start = 1'b0;
        check("busy_after_start", longint'(busy), 1);
        while (beat < k && guard < 2000) begin
            load_beat(beat);
            in_valid = rnd_in ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            acc = in_valid && in_ready;
            tick;
            guard++;
            if (acc) begin
                beat++;
                if (beat == k) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                    check("latency_valid", longint'(out_valid), 1);
                    check("latency_idx", longint'(out_idx), 0);
                    tick;
                end
            end
        end
        in_valid = 1'b0;
        if (beat < k) check("beat_timeout", beat, k);
        guard = 0;
        while (done_cnt == d0 && guard < 2000) begin
            out_ready = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = start_in_drain && busy;
            tick;
            guard++;
        end
        out_ready = 1'b0;
        start     = 1'b0;
        check("done_seen", done_cnt - d0, 1);
        check("idle_after_done", longint'(busy), 0);
        tick; tick;
        check("done_once", done_cnt - d0, 1);
        check("rows_complete", exp_row, 0);
    endtask

    initial begin
        int d0;
        // Reset state.
        rst = 1'b1;
        tick; tick;
        @(negedge clk);
        check("rst_busy", longint'(busy), 0);
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_last", longint'(out_last), 0);
        check("rst_done", longint'(done), 0);
        check("rst_out_row", longint'(out_row), 0);
        check("rst_out_idx", longint'(out_idx), 0);
        tick;
        rst = 1'b0;
        tick;

        // Identity A times B[r][c] = r*4+c returns B.
        for (int t = 0; t < M; t++)
            for (int i = 0; i < M; i++) begin
                a_b[t][i] = (i == t) ? 1 : 0;
                b_b[t][i] = t * 4 + i;
            end
        run_job(4, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
                check("ident_lit", got_mat[i][j], i * 4 + j);

        // -128 * -128 three times: saturate vs wrap.
        for (int t = 0; t < 3; t++)
            for (int i = 0; i < M; i++) begin
                a_b[t][i] = -128;
                b_b[t][i] = -128;
            end
        run_job(3, 1'b1, 1'b0, 1'b0, 1'b0);
        check("sat_model_lit", exp_mat[2][1], 32767);
        check("sat_lit_00", got_mat[0][0], 32767);
        check("sat_lit_33", got_mat[3][3], 32767);
        run_job(3, 1'b0, 1'b0, 1'b0, 1'b0);
        check("wrap_model_lit", exp_mat[1][2], -16384);
        check("wrap_lit_00", got_mat[0][0], -16384);
        check("wrap_lit_32", got_mat[3][2], -16384);

        // Zero-length job drains four zero rows.
        run_job(0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
                check("k0_zero", got_mat[i][j], 0);

        // Random operands with random throttling on both sides.
        for (int r = 0; r < 2; r++) begin
            for (int t = 0; t < 7; t++)
                for (int i = 0; i < M; i++) begin
                    a_b[t][i] = int'($urandom_range(0, 255)) - 128;
                    b_b[t][i] = int'($urandom_range(0, 255)) - 128;
                end
            run_job(7, r[0], 1'b1, 1'b1, 1'b0);
        end

        // Abort after 2 of 5 beats.
        for (int t = 0; t < 5; t++)
            for (int i = 0; i < M; i++) begin
                a_b[t][i] = 3;
                b_b[t][i] = 5;
            end
        d0 = done_cnt;
        start = 1'b1; k_len = KW'(5); sat_en = 1'b0;
        tick;
        start = 1'b0;
        for (int t = 0; t < 2; t++) begin
            load_beat(t);
            in_valid = 1'b1;
            tick;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_row = 0;
        @(negedge clk);
        check("abort_busy", longint'(busy), 0);
        check("abort_in_ready", longint'(in_ready), 0);
        tick; tick; tick;
        check("abort_no_done", done_cnt - d0, 0);
        for (int i = 0; i < M; i++) begin
            a_b[0][i] = 1;
            b_b[0][i] = 2;
        end
        run_job(1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
                check("after_abort_lit", got_mat[i][j], 2);

        // start held during DRAIN has no effect.
        for (int t = 0; t < 4; t++)
            for (int i = 0; i < M; i++) begin
                a_b[t][i] = int'($urandom_range(0, 255)) - 128;
                b_b[t][i] = int'($urandom_range(0, 255)) - 128;
            end
        run_job(4, 1'b0, 1'b0, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_array_seq.md
MAC_ARRAY_SEQ -- requirements
Module: mac_array_seq

Interface
REQ-001 Parameter M, default 4, array dimension; the block computes an M x M result, and M SHALL be at least 2.
REQ-002 Parameter A_WIDTH, default 8, signed width of each A element.
REQ-003 Parameter B_WIDTH, default 8, signed width of each B element.
REQ-004 Parameter ACC_WIDTH, default 32, signed accumulator width; it SHALL be at least A_WIDTH+B_WIDTH.
REQ-005 Parameter K_WIDTH, default 16, width of the reduction-length field.
REQ-006 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 start  in  1  begins a job; sampled in IDLE only.
REQ-009 k_len  in  K_WIDTH  number of input beats (reduction depth); sampled with start.
REQ-010 sat_en  in  1  1 = saturating accumulation, 0 = two's-complement wrap; sampled with start.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 in_valid  in  1  input beat valid.
REQ-013 in_ready  out  1  input beat accepted when in_valid and in_ready are both high.
REQ-014 a_col  in  M x A_WIDTH signed  one column of A (element i feeds row i).
REQ-015 b_row  in  M x B_WIDTH signed  one row of B (element j feeds column j).
REQ-016 out_valid  out  1  result row valid.
REQ-017 out_ready  in  1  result row accepted when out_valid and out_ready are both high.
REQ-018 out_row  out  M x ACC_WIDTH signed  accumulator row acc[out_idx][0..M-1].
REQ-019 out_idx  out  $clog2(M)  index of the row on out_row.
REQ-020 out_last  out  1  high with out_valid when out_idx equals M-1.
REQ-021 done  out  1  one-cycle pulse after the final row handshake.

Function
REQ-022 The FSM SHALL have exactly three states: IDLE, ACCUM and DRAIN.
REQ-023 In IDLE, start=1 SHALL latch k_len and sat_en, clear all M*M accumulators to 0, and go to ACCUM, or to DRAIN if k_len equals 0.
REQ-024 start SHALL be ignored in ACCUM and in DRAIN.
REQ-025 in_ready SHALL be 1 in ACCUM only and SHALL not depend combinationally on in_valid.
REQ-026 Each accepted beat SHALL update every acc[i][j] at the same clock edge with acc[i][j] + a_col[i]*b_row[j], using an exact (A_WIDTH+B_WIDTH)-bit signed product sign-extended to ACC_WIDTH.
REQ-027 With sat_en=1, each sum SHALL clamp to the range [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; with sat_en=0, each sum SHALL wrap modulo 2^ACC_WIDTH.
REQ-028 A beat counter SHALL count accepted beats; on the k_len-th beat the FSM SHALL enter DRAIN at that edge, and out_valid SHALL be 1 in the next cycle with final data (latency 1).
REQ-029 In ACCUM, in_valid=0 SHALL leave the accumulators and the counter unchanged; stalls of any length SHALL be legal.
REQ-030 In DRAIN, out_valid SHALL be 1 and out_idx SHALL start at 0 and increment on each handshake.
REQ-031 out_row, out_idx and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-032 The handshake on row M-1 SHALL return the FSM to IDLE and pulse done in the following cycle; accumulators SHALL retain their values until the next start.
REQ-033 out_valid SHALL be 0 outside DRAIN.

Reset
REQ-034 rst=1 SHALL force IDLE, clear the accumulators, beat counter and row index, and drive busy, in_ready, out_valid, out_last and done to 0; out_row SHALL read 0 and out_idx SHALL be 0.
REQ-035 rst asserted mid-ACCUM or mid-DRAIN SHALL abort the job with no done pulse, and a start after reset SHALL run normally.

Structure
REQ-036 Package mac_pkg SHALL hold the state enum (IDLE, ACCUM, DRAIN) and the saturating-add function.
REQ-037 One sub-module, mac_cell_sat, SHALL hold one accumulator with clear, enable and sat_en, and SHALL be instantiated M*M times by a generate loop.

Verification
REQ-038 M=4, k_len=4, A=identity, B has element [r][c]=r*4+c, with no stalls: out rows SHALL equal B, out_last SHALL be 1 on row 3, and done SHALL pulse once.
REQ-039 k_len=3, a_col all -128, b_row all -128, ACC_WIDTH=16: sat_en=1 SHALL give every element 32767; sat_en=0 SHALL give 49152 mod 2^16, which reads as -16384.
REQ-040 k_len=0 then start: DRAIN SHALL be entered directly and four all-zero rows SHALL be output.
REQ-041 Random in_valid and out_ready throttling, k_len=7, random operands: results SHALL match a reference model, and outputs SHALL hold stable during every stall.
REQ-042 rst pulsed after 2 of 5 beats: busy SHALL fall, no done pulse SHALL occur, and the next job (k_len=1, a_col=1, b_row=2) SHALL give all elements equal to 2.
REQ-043 start asserted during DRAIN SHALL have no effect on the row sequence or on the results.
